pulse_train_gen: RTL and testbench
==================================

Name: pulse_train_gen

Overview:
- Turns a single-cycle trigger into a programmable train of rectangular pulses on one output line.
- It is the complement of the team's edge detector: that block reduces a level change to a one-cycle pulse; this block expands a one-cycle pulse into timed level changes.
- Used to drive strobes, chip-selects and test stimulus from trigger pulses (often produced by pos_edge_det), all in one clock domain.

Parameters:
- TW, 8: width of the high/low duration inputs and their internal counter.
- NW, 8: width of the pulse-count input and its internal counter.

Ports:
- clk  in  1  system clock; all logic updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  trigger, sampled only in IDLE; typically a one-cycle pulse.
- high_cycles  in  TW  high time per pulse, in clocks; 0 is treated as 1.
- low_cycles  in  TW  gap between pulses, in clocks; 0 is treated as 1.
- num_pulses  in  NW  number of pulses in the train; 0 means an empty train.
- out  out  1  generated pulse train (registered).
- busy  out  1  high while a train is in progress (registered).
- done  out  1  one-cycle completion strobe (registered).

Behaviour:
- Reset: rst_n sampled low at a rising edge gives out=0, busy=0, done=0 and state=IDLE, all counters 0.
- Reset mid-train aborts the train immediately. No done pulse is issued for the aborted train.
- States: IDLE, HIGH, LOW.
- IDLE:
  - out=0, busy=0.
  - start=1 latches high_cycles, low_cycles and num_pulses into internal registers.
  - If num_pulses != 0: go to HIGH. Next cycle out=1, busy=1.
  - If num_pulses == 0: stay in IDLE. Next cycle done=1; out and busy stay 0.
- HIGH:
  - out=1 for exactly max(H,1) cycles, where H is the latched high_cycles.
  - After that, if pulses remain: go to LOW.
  - After the last pulse: go to IDLE. That cycle has out=0, busy=0, done=1.
- LOW:
  - out=0, busy=1 for exactly max(L,1) cycles, where L is the latched low_cycles.
  - Then go to HIGH.
- No trailing low period after the last pulse.
- Latency: start sampled at the edge ending cycle k puts out=1 in cycle k+1.
- Total train length from the first out=1 cycle to the done cycle (exclusive): N*max(H,1) + (N-1)*max(L,1) cycles.
- done:
  - Exactly one cycle wide.
  - Coincides with the first IDLE cycle after a train.
  - Also asserted one cycle after start when num_pulses==0.
- start in the done cycle is accepted, so back-to-back trains are possible. The gap between trains is exactly 1 low cycle.
- start while busy=1 is ignored: not queued, no effect on the running train.
- Config inputs changing while busy=1 have no effect; only values latched at start are used.
- Counters:
  - Down-counters, loaded with max(value,1)-1.
  - Each phase ends when its counter reaches 0; no wrap-around.
  - Maximum values (2^TW-1, 2^NW-1) are supported exactly.
- out, busy and done are registered. No combinational path from any input to any output.

Test Plan:
- Basic train: rst_n low 2 cycles, then start at cycle 10 with H=3, L=2, N=2.
  - out=1 in cycles 11-13, 0 in 14-15, 1 in 16-18.
  - done=1 and busy=0 in cycle 19.
  - done high for exactly 1 cycle.
- Zero values: start with H=0, L=0, N=3.
  - out pattern from cycle k+1 is 1,0,1,0,1.
  - done in cycle k+6.
- Empty train: start with N=0 → out stays 0, busy stays 0, done=1 in cycle k+1 only.
- Ignored start and latched config:
  - Start H=4, L=1, N=1.
  - Pulse start again and change H to 9 two cycles later.
  - Required: a single out pulse of 4 cycles and one done.
- Back-to-back: assert start in the done cycle of a train (H=1, L=1, N=1).
  - Second pulse begins the next cycle.
  - Exactly 1 low cycle between the two trains.
- Reset mid-operation: rst_n low during HIGH of a H=5, N=3 train.
  - out=0 and busy=0 the cycle after the reset edge.
  - done never asserts; a subsequent start behaves as in the basic train test.
- Max bounds: H=255, N=1 with TW=8 → out high for exactly 255 cycles.

Source files
------------

// File: rtl/pulse_train_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pulse_train_gen                                              |
// | Description : Expands a one-cycle start trigger into a train of N pulses,  |
// |               each high for max(H,1) clocks, separated by max(L,1) clocks. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pulse_train_gen #(
    parameter int TW = 8,
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [TW-1:0] high_cycles,
    input  logic [TW-1:0] low_cycles,
    input  logic [NW-1:0] num_pulses,
    output logic          out,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HIGH = 2'd1;
    localparam logic [1:0] c_ST_LOW  = 2'd2;

    logic [1:0]    r_state;
    logic [TW-1:0] r_cnt_t;
    logic [TW-1:0] r_high_load;
    logic [TW-1:0] r_low_load;
    logic [NW-1:0] r_cnt_n;
    logic          r_out;
    logic          r_busy;
    logic          r_done;

    logic [TW-1:0] w_high_load;
    logic [TW-1:0] w_low_load;

    // A zero duration behaves as one cycle, so both 0 and 1 load a count of 0.
    assign w_high_load = (high_cycles == '0) ? '0 : high_cycles - TW'(1);
    assign w_low_load  = (low_cycles  == '0) ? '0 : low_cycles  - TW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_cnt_t     <= '0;
            r_cnt_n     <= '0;
            r_high_load <= '0;
            r_low_load  <= '0;
            r_out       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_out  <= 1'b0;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_high_load <= w_high_load;
                        r_low_load  <= w_low_load;
                        if (num_pulses != '0) begin
                            r_state <= c_ST_HIGH;
                            r_cnt_t <= w_high_load;
                            // r_cnt_n counts pulses still to come after this one
                            r_cnt_n <= num_pulses - NW'(1);
                            r_out   <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end

                c_ST_HIGH: begin
                    if (r_cnt_t != '0) begin
                        r_cnt_t <= r_cnt_t - TW'(1);
                    end else if (r_cnt_n != '0) begin
                        r_state <= c_ST_LOW;
                        r_cnt_t <= r_low_load;
                        r_out   <= 1'b0;
                    end else begin
                        r_state <= c_ST_IDLE;
                        r_out   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                c_ST_LOW: begin
                    if (r_cnt_t != '0) begin
                        r_cnt_t <= r_cnt_t - TW'(1);
                    end else begin
                        r_state <= c_ST_HIGH;
                        r_cnt_t <= r_high_load;
                        r_cnt_n <= r_cnt_n - NW'(1);
                        r_out   <= 1'b1;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_out   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pulse_train_gen                                           |
// | Description : Self-checking bench for pulse_train_gen against a waveform   |
// |               schedule model, plus literal expectations for key scenarios. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pulse_train_gen;

    localparam int TW = 8;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [TW-1:0] high_cycles = '0;
    logic [TW-1:0] low_cycles = '0;
    logic [NW-1:0] num_pulses = '0;
    logic          out;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    bit model_en = 1'b0;

    always #5 clk = ~clk;

    pulse_train_gen #(.TW(TW), .NW(NW)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .high_cycles(high_cycles),
        .low_cycles (low_cycles),
        .num_pulses (num_pulses),
        .out        (out),
        .busy       (busy),
        .done       (done)
    );

    // Model: each accepted start expands into the full list of future
    // {out,busy,done} values; one entry is consumed per clock.
    logic [2:0] exp_q[$];
    logic [2:0] cur = 3'b000;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            cur = 3'b000;
        end else begin
            if (!cur[1] && start) begin
                int h;
                int l;
                int n;
                h = (high_cycles == 0) ? 1 : int'(high_cycles);
                l = (low_cycles == 0) ? 1 : int'(low_cycles);
                n = int'(num_pulses);
                for (int p = 0; p < n; p++) begin
                    repeat (h) exp_q.push_back(3'b110);
                    if (p < n - 1) repeat (l) exp_q.push_back(3'b010);
                end
                exp_q.push_back(3'b001);
            end
            cur = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b000;
        end
    end

    always @(negedge clk) begin
        if (model_en) begin
            checks++;
            if ({out, busy, done} !== cur) begin
                errors++;
                $display("FAIL model t=%0t out/busy/done got %b%b%b want %b", $time, out, busy, done, cur);
            end
        end
    end

    // Window counters for pulse-width and done-count checks
    bit cnt_en = 1'b0;
    int hi_cnt = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (cnt_en) begin
            if (out === 1'b1) hi_cnt++;
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic pulse_start(input int h, input int l, input int n);
        @(posedge clk); #2;
        start = 1'b1;
        high_cycles = TW'(h);
        low_cycles = TW'(l);
        num_pulses = NW'(n);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic trace(input int len, output logic [31:0] o, output logic [31:0] b,
                         output logic [31:0] d);
        o = '0; b = '0; d = '0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            o = {o[30:0], out};
            b = {b[30:0], busy};
            d = {d[30:0], done};
        end
    endtask

    task automatic basic_train(input string tag);
        logic [31:0] o, b, d;
        pulse_start(3, 2, 2);
        trace(10, o, b, d);
        lit({tag, "_out"},  o, 32'b1110011100);
        lit({tag, "_busy"}, b, 32'b1111111100);
        lit({tag, "_done"}, d, 32'b0000000010);
    endtask

    initial begin
        logic [31:0] o, b, d;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        model_en = 1'b1;
        @(negedge clk);
        lit("reset_state", {out, busy, done}, 3'b000);

        repeat (6) @(posedge clk);
        basic_train("basic");

        pulse_start(0, 0, 3);
        trace(6, o, b, d);
        lit("zero_out",  o, 32'b101010);
        lit("zero_done", d, 32'b000001);

        repeat (3) @(posedge clk);
        pulse_start(7, 7, 0);
        trace(2, o, b, d);
        lit("empty_out",  o, 32'b00);
        lit("empty_busy", b, 32'b00);
        lit("empty_done", d, 32'b10);

        // Second start and config change while busy must not disturb the train
        repeat (2) @(posedge clk);
        hi_cnt = 0; done_cnt = 0; cnt_en = 1'b1;
        pulse_start(4, 1, 1);
        @(posedge clk); #2;
        start = 1'b1; high_cycles = 8'd9;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 cnt_en = 1'b0;
        lit("ignored_hi_cnt", hi_cnt, 4);
        lit("ignored_done_cnt", done_cnt, 1);

        // Back-to-back: restart in the done cycle
        pulse_start(1, 1, 1);
        @(negedge clk);
        o = {31'b0, out}; d = {31'b0, done};
        @(posedge clk); #2;
        start = 1'b1;
        @(negedge clk);
        o = {o[30:0], out}; d = {d[30:0], done};
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk);
        o = {o[30:0], out}; d = {d[30:0], done};
        @(negedge clk);
        o = {o[30:0], out}; d = {d[30:0], done};
        lit("b2b_out",  o, 32'b1010);
        lit("b2b_done", d, 32'b0101);

        // Reset in the middle of a high phase
        repeat (2) @(posedge clk);
        pulse_start(5, 2, 3);
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        lit("midrst_out_busy", {out, busy}, 2'b00);
        done_cnt = 0; cnt_en = 1'b1;
        repeat (30) @(posedge clk);
        #2 cnt_en = 1'b0;
        lit("midrst_no_done", done_cnt, 0);
        basic_train("post_rst");

        // Maximum pulse width and maximum pulse count
        hi_cnt = 0; done_cnt = 0; cnt_en = 1'b1;
        pulse_start(255, 0, 1);
        repeat (262) @(posedge clk);
        #2 cnt_en = 1'b0;
        lit("max_h_hi_cnt", hi_cnt, 255);
        lit("max_h_done_cnt", done_cnt, 1);

        hi_cnt = 0; done_cnt = 0; cnt_en = 1'b1;
        pulse_start(0, 0, 255);
        repeat (515) @(posedge clk);
        #2 cnt_en = 1'b0;
        lit("max_n_hi_cnt", hi_cnt, 255);
        lit("max_n_done_cnt", done_cnt, 1);

        // Random stimulus, including occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 4) == 0);
            high_cycles = TW'($urandom_range(0, 5));
            low_cycles = TW'($urandom_range(0, 5));
            num_pulses = NW'($urandom_range(0, 4));
            rst_n = ($urandom_range(0, 249) != 0);
        end
        @(posedge clk); #2;
        start = 1'b0;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
